// File: rtl/display_if.sv
// display_if: start/done handshake and result bus of the display parser.
// Signals: start, formatted_in (requester -> parser); busy, done, value, remainder, error (parser -> requester).
interface display_if #(
    parameter int WIDTH  = 21,
    parameter int DIGITS = 8
);
    logic                  start;
    logic [4*DIGITS-1:0]   formatted_in;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      value;
    logic [WIDTH-1:0]      remainder;
    logic                  error;
    modport master (output start, formatted_in, input busy, done, value, remainder, error);
    modport slave  (input start, formatted_in, output busy, done, value, remainder, error);
endinterface

// File: rtl/display_parser.sv
// display_parser: converts a packed display-nibble word back to a signed operand, one nibble per clock.
// Ports: clock, reset (async, active-high); bus (display_if.slave): start/formatted_in in, busy/done/value/remainder/error out.
// Macro FMT_REMAINDER_EN: when defined, code 1010 is a decimal point and digits after it form the remainder.
module display_parser #(
    parameter int WIDTH  = 21,
    parameter int DIGITS = 8
) (
    input  logic     clock,
    input  logic     reset,
    display_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;
    localparam int AW = WIDTH + 4;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [AW-1:0] NEG_MAX = AW'(1) << (WIDTH - 1);
    localparam logic [AW-1:0] POS_MAX = NEG_MAX - AW'(1);

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] word_q, word_d;
    logic [AW-1:0]       int_acc_q, int_acc_d, int_next;
    logic                neg_q, neg_d, seen_nb_q, seen_nb_d, int_dig_q, int_dig_d, err_q, err_d;
    logic                done_q, done_d, error_q, error_d, fail;
    logic [WIDTH-1:0]    value_q, value_d;
    logic [3:0]          nib;
`ifdef FMT_REMAINDER_EN
    logic [AW-1:0]       rem_acc_q, rem_acc_d, rem_next;
    logic                pt_q, pt_d, frac_dig_q, frac_dig_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
`endif

    assign nib      = word_q[{idx_q, 2'b00} +: 4];
    assign int_next = (int_acc_q << 3) + (int_acc_q << 1) + AW'(nib);
`ifdef FMT_REMAINDER_EN
    assign rem_next = (rem_acc_q << 3) + (rem_acc_q << 1) + AW'(nib);
    assign fail     = err_q | !int_dig_q | (!neg_q && int_acc_q > POS_MAX) | (pt_q && !frac_dig_q);
`else
    assign fail     = err_q | !int_dig_q | (!neg_q && int_acc_q > POS_MAX);
`endif

    assign bus.busy  = state_q != IDLE;
    assign bus.done  = done_q;
    assign bus.value = value_q;
    assign bus.error = error_q;
`ifdef FMT_REMAINDER_EN
    assign bus.remainder = rem_q;
`else
    assign bus.remainder = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            word_q    <= '0;
            int_acc_q <= '0;
            neg_q     <= 1'b0;
            seen_nb_q <= 1'b0;
            int_dig_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            value_q   <= '0;
`ifdef FMT_REMAINDER_EN
            rem_acc_q  <= '0;
            pt_q       <= 1'b0;
            frac_dig_q <= 1'b0;
            rem_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            int_acc_q <= int_acc_d;
            neg_q     <= neg_d;
            seen_nb_q <= seen_nb_d;
            int_dig_q <= int_dig_d;
            err_q     <= err_d;
            done_q    <= done_d;
            error_q   <= error_d;
            value_q   <= value_d;
`ifdef FMT_REMAINDER_EN
            rem_acc_q  <= rem_acc_d;
            pt_q       <= pt_d;
            frac_dig_q <= frac_dig_d;
            rem_q      <= rem_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        int_acc_d = int_acc_q;
        neg_d     = neg_q;
        seen_nb_d = seen_nb_q;
        int_dig_d = int_dig_q;
        err_d     = err_q;
        done_d    = 1'b0;
        error_d   = error_q;
        value_d   = value_q;
`ifdef FMT_REMAINDER_EN
        rem_acc_d  = rem_acc_q;
        pt_d       = pt_q;
        frac_dig_d = frac_dig_q;
        rem_d      = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SCAN;
                    idx_d     = IW'(DIGITS - 1);
                    word_d    = bus.formatted_in;
                    int_acc_d = '0;
                    neg_d     = 1'b0;
                    seen_nb_d = 1'b0;
                    int_dig_d = 1'b0;
                    err_d     = 1'b0;
                    error_d   = 1'b0;
`ifdef FMT_REMAINDER_EN
                    rem_acc_d  = '0;
                    pt_d       = 1'b0;
                    frac_dig_d = 1'b0;
`endif
                end
            end
            SCAN: begin
                // Error flag is sticky; accumulators may run on after an error since the result is discarded.
                if (nib == 4'hF) begin
                    if (seen_nb_q) err_d = 1'b1;
                end else if (nib == 4'hE) begin
                    if (seen_nb_q) err_d = 1'b1;
                    neg_d     = 1'b1;
                    seen_nb_d = 1'b1;
`ifdef FMT_REMAINDER_EN
                end else if (nib == 4'hA) begin
                    if (!int_dig_q || pt_q) err_d = 1'b1;
                    pt_d      = 1'b1;
                    seen_nb_d = 1'b1;
                end else if (nib <= 4'd9 && pt_q) begin
                    seen_nb_d  = 1'b1;
                    frac_dig_d = 1'b1;
                    rem_acc_d  = rem_next;
                    if (rem_next > POS_MAX) err_d = 1'b1;
`endif
                end else if (nib <= 4'd9) begin
                    // Bounding at NEG_MAX keeps acc*10+9 inside AW bits on later digits.
                    seen_nb_d = 1'b1;
                    int_dig_d = 1'b1;
                    int_acc_d = int_next;
                    if (int_next > NEG_MAX) err_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = idx_q == '0 ? FINISH : SCAN;
                idx_d   = idx_q == '0 ? idx_q : idx_q - 1'b1;
            end
            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                error_d = fail;
                value_d = fail ? '0 : neg_q ? -int_acc_q[WIDTH-1:0] : int_acc_q[WIDTH-1:0];
`ifdef FMT_REMAINDER_EN
                rem_d   = fail ? '0 : rem_acc_q[WIDTH-1:0];
`endif
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_display_parser.sv
// tb_display_parser: directed stimulus with a scoreboard queue checked by an independent done monitor.
module tb_display_parser;
    localparam int WIDTH  = 21;
    localparam int DIGITS = 8;

    typedef struct {
        string            n;
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] r;
        logic             e;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t q[$];

    display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();
    display_parser #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (.clock(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk({x.n, "_value"}, 32'(bus.value), 32'(x.v));
                chk({x.n, "_remainder"}, 32'(bus.remainder), 32'(x.r));
                chk({x.n, "_error"}, 32'(bus.error), 32'(x.e));
                chk({x.n, "_latency"}, 32'(cyc), 32'(x.cyc));
            end
        end
    end

    task automatic wait_done();
        int k;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        chk("done_timeout", 32'(k < 30), 32'd1);
    endtask

    task automatic issue(input string n, input logic [31:0] w, input logic [WIDTH-1:0] v,
                         input logic [WIDTH-1:0] r, input logic e);
        exp_t x;
        x.n = n; x.v = v; x.r = r; x.e = e; x.cyc = cyc + 1 + DIGITS + 1;
        q.push_back(x);
        bus.formatted_in = w;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run(input string n, input logic [31:0] w, input logic [WIDTH-1:0] v,
                       input logic [WIDTH-1:0] r, input logic e);
        issue(n, w, v, r, e);
        wait_done();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.formatted_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_value", 32'(bus.value), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run("neg123", 32'hFFFFE123, 21'h1FFF85, 21'd0, 1'b0);
`ifdef FMT_REMAINDER_EN
        run("point", 32'hFFF12A34, 21'd12, 21'd34, 1'b0);
`else
        run("point", 32'hFFF12A34, 21'd0, 21'd0, 1'b1);
`endif
        run("pos_max", 32'hF1048575, 21'h0FFFFF, 21'd0, 1'b0);
        run("neg_max", 32'hE1048576, 21'h100000, 21'd0, 1'b0);
        run("pos_ovf", 32'hF1048576, 21'd0, 21'd0, 1'b1);
        run("all9", 32'h99999999, 21'd0, 21'd0, 1'b1);
        run("emb_blank", 32'hFF1F2FFF, 21'd0, 21'd0, 1'b1);
        run("late_minus", 32'hFFF1E2FF, 21'd0, 21'd0, 1'b1);
        run("all_blank", 32'hFFFFFFFF, 21'd0, 21'd0, 1'b1);
        run("pt_blank", 32'hFFFF12AF, 21'd0, 21'd0, 1'b1);
        run("bad_code", 32'hFFFFF1B2, 21'd0, 21'd0, 1'b1);
        run("minus_zero", 32'hFFFFFFE0, 21'd0, 21'd0, 1'b0);

        issue("repulse", 32'hFFFFF777, 21'd777, 21'd0, 1'b0);
        chk("busy_scan", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.formatted_in = 32'hFFFFF111;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (15) @(negedge clk);

        run("pre_reset", 32'hFFFFE123, 21'h1FFF85, 21'd0, 1'b0);
        bus.formatted_in = 32'hFFFF9999;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_value", 32'(bus.value), 32'd0);
        chk("abort_error", 32'(bus.error), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_idle", 32'(bus.busy), 32'd0);

        run("after_reset", 32'hFFFFFF42, 21'd42, 21'd0, 1'b0);
        repeat (15) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/display_parser.md
Name: display_parser

Overview:
- Inverse of the calculator's result formatter: takes a packed 8-nibble display word and converts it back to a signed binary operand, plus an optional remainder.
- The display word uses the display nibble code: 0-9 digit, 1010 point, 1110 minus, 1111 blank.
- Scans one nibble per clock, MSB nibble first, with a start/done handshake.
- Feeds re-entered or recalled display values into the ALU operand path.

Parameters:
- WIDTH, 21, width of value/remainder outputs; two's complement value.
- DIGITS, 8, number of 4-bit nibbles in formatted_in.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request conversion; sampled only in IDLE.
- formatted_in  input  4*DIGITS  packed display word; nibble DIGITS-1 is leftmost on the display.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; value/remainder/error valid.
- value  output  WIDTH  signed integer part.
- remainder  output  WIDTH  unsigned digits after the point.
- error  output  1  conversion failed; valid with done, held until next start.

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE. Reset asserted mid-scan aborts the conversion; no done is issued.
- Input capture: formatted_in is registered when start is accepted, so later input changes do not affect the conversion.
- States and timing:
  - IDLE: start=1 accepts the request; go to SCAN with nibble index DIGITS-1 and clear accumulators/flags.
  - SCAN: one nibble per cycle for DIGITS cycles, index decrementing, then FINISH.
  - FINISH: apply sign, load outputs, pulse done, return to IDLE.
  - Latency: start accepted at cycle N; done at N+DIGITS+1 (N+9 by default).
  - A new start is accepted the cycle after done.
  - start while busy is ignored; no queueing.
- Scan grammar, left to right: leading blanks, optional minus, one or more digits, then optional point followed by one or more digits.
- Error conditions; the error sticks for the rest of the scan:
  - codes 1011/1100/1101;
  - minus not first non-blank;
  - second minus or second point;
  - blank after the first non-blank;
  - no integer digits, or point with no following digits;
  - all-blank word.
- Arithmetic:
  - Each digit updates the accumulator: acc = (acc<<3) + (acc<<1) + d.
  - The integer accumulator is WIDTH+4 bits internal, so no intermediate wrap occurs.
  - Integer overflow: magnitude > 2^(WIDTH-1)-1 if positive, or > 2^(WIDTH-1) if negative, sets error.
  - Remainder overflow: remainder > 2^(WIDTH-1)-1 sets error.
  - Negative result: value = two's complement of magnitude; "-0" gives value 0.
  - remainder is never signed.
  - On error, value=0 and remainder=0.

Optional Feature:
- Macro FMT_REMAINDER_EN.
- Defined: the point code 1010 splits integer and remainder digits as described above.
- Undefined:
  - 1010 is an invalid code and sets error.
  - remainder is tied to 0 and its accumulator logic is removed.

Test Plan:
- formatted_in=0xFFFFE123, start -> done exactly 9 cycles after start; value=21'h1FFF85 (-123), remainder=0, error=0.
- 0xFFF12A34 with FMT_REMAINDER_EN -> value=12, remainder=34, error=0. Without the macro -> error=1, value=0.
- Boundaries:
  - 0xF1048575 -> value=21'h0FFFFF, error=0.
  - 0xE1048576 -> value=21'h100000, error=0.
  - 0xF1048576 -> error=1.
  - 0x99999999 -> error=1.
- Grammar errors, each -> error=1, value=0:
  - 0xFF1F2FFF (embedded blank);
  - 0xFFF1E2FF (late minus);
  - 0xFFFFFFFF (all blank);
  - 0xFFFF12AF (point then blank).
- start re-pulsed at cycles 3 and 5 of a scan -> ignored; exactly one done, result for the original word. Changing formatted_in mid-scan has no effect.
- reset asserted at scan cycle 4 -> busy=0, done never pulses, outputs=0. A following start on 0xFFFFFF42 -> value=42.
